// File: rtl/rcc_ker_clk_sel_ctrl.sv
// Kernel-clock source sequencer: request, ready-wait, gate-off, switch, settle, gate-on,
// with ready timeout, automatic fallback on source failure and sticky status flags.
module rcc_ker_clk_sel_ctrl #(
  parameter int unsigned SRC_NUM      = 4,
  parameter int unsigned SEL_W        = 2,
  parameter int unsigned FALLBACK_SRC = 2,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned RDY_TIMEOUT  = 200,
  parameter int unsigned GATE_CYC     = 4,
  parameter int unsigned RST_HOLD     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               testmode,
  input  logic               sw_en,
  input  logic [SEL_W-1:0]   sw_sel,
  input  logic [SRC_NUM-1:0] src_rdy,
  input  logic [SRC_NUM-1:0] src_fail,
  input  logic               fail_clr,
  output logic [SEL_W-1:0]   clk_sel_o,
  output logic               clk_gate_en,
  output logic               ker_rst_n,
  output logic               busy,
  output logic               fail_flag,
  output logic               fallback_act,
  output logic               timeout_err
);

  localparam int unsigned      SEL_N     = 1 << SEL_W;
  localparam logic [SEL_W:0]   SRC_LIM   = (SEL_W+1)'(SRC_NUM);
  localparam logic [SEL_W-1:0] FB        = SEL_W'(FALLBACK_SRC);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(RDY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD      = CNT_W'(RST_HOLD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_GOFF,
    S_SWITCH,
    S_ACTIVE
  } state_e;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] tgt_q, tgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             from_act_q, from_act_d;
  logic             gate_q, gate_d;
  logic             krst_q, krst_d;
  logic             busy_q, busy_d;
  logic             ff_q, ff_d;
  logic             fa_q, fa_d;
  logic             te_q, te_d;
  logic             ff_set, fa_set, te_set;

  logic [SEL_N-1:0] rdy_v, fail_v;
  logic [SEL_W-1:0] req;

  // Source vectors widened to the select range; index 0 ("no clock") is never ready or failing.
  assign rdy_v  = SEL_N'(src_rdy)  & ~SEL_N'(1);
  assign fail_v = SEL_N'(src_fail) & ~SEL_N'(1);
  assign req    = (sw_en && (sw_sel != '0) && ({1'b0, sw_sel} < SRC_LIM)) ? sw_sel : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      tgt_q      <= '0;
      cnt_q      <= '0;
      from_act_q <= 1'b0;
      gate_q     <= 1'b0;
      krst_q     <= 1'b0;
      busy_q     <= 1'b0;
      ff_q       <= 1'b0;
      fa_q       <= 1'b0;
      te_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      tgt_q      <= tgt_d;
      cnt_q      <= cnt_d;
      from_act_q <= from_act_d;
      gate_q     <= gate_d;
      krst_q     <= krst_d;
      busy_q     <= busy_d;
      ff_q       <= ff_d;
      fa_q       <= fa_d;
      te_q       <= te_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    tgt_d      = tgt_q;
    cnt_d      = cnt_q;
    from_act_d = from_act_q;
    ff_set     = 1'b0;
    fa_set     = 1'b0;
    te_set     = 1'b0;

    case (state_q)
      S_IDLE: begin
        from_act_d = 1'b0;
        if (req != '0) begin
          tgt_d   = req;
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (req == '0) begin
          // A running clock must be gated off properly rather than dropped.
          cnt_d = '0;
          if (from_act_q) begin
            tgt_d   = '0;
            state_d = S_GOFF;
          end else begin
            state_d = S_IDLE;
          end
        end else if (from_act_q && (req == sel_q)) begin
          tgt_d   = sel_q;
          cnt_d   = HOLD;
          state_d = S_ACTIVE;
        end else if (req != tgt_q) begin
          tgt_d = req;
          cnt_d = '0;
        end else if (rdy_v[tgt_q] && !fail_v[tgt_q]) begin
          cnt_d   = '0;
          state_d = S_GOFF;
        end else if (cnt_q == TO_LAST) begin
          te_set = 1'b1;
          if (from_act_q) begin
            tgt_d   = sel_q;
            cnt_d   = HOLD;
            state_d = S_ACTIVE;
          end else begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_GOFF: begin
        from_act_d = 1'b0;
        if (cnt_q == GATE_LAST) begin
          sel_d   = tgt_q;
          cnt_d   = '0;
          state_d = S_SWITCH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_SWITCH: begin
        if (cnt_q == GATE_LAST) begin
          cnt_d   = '0;
          state_d = (sel_q != '0) ? S_ACTIVE : S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_ACTIVE: begin
        if (fail_v[sel_q]) begin
          ff_set  = 1'b1;
          cnt_d   = '0;
          state_d = S_GOFF;
          if ((sel_q != FB) && rdy_v[FB] && !fail_v[FB]) begin
            tgt_d  = FB;
            fa_set = 1'b1;
          end else begin
            tgt_d = '0;
          end
        end else if (req == '0) begin
          tgt_d   = '0;
          cnt_d   = '0;
          state_d = S_GOFF;
        end else if (!fa_q && (req != sel_q)) begin
          tgt_d      = req;
          cnt_d      = '0;
          from_act_d = 1'b1;
          state_d    = S_WAIT;
        end else if (cnt_q < HOLD) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Old clock keeps running (and out of reset) while a new source is awaited from ACTIVE.
    gate_d = (state_d == S_ACTIVE) || ((state_d == S_WAIT) && from_act_d);
    krst_d = ((state_d == S_ACTIVE) && (cnt_d >= HOLD)) ||
             ((state_d == S_WAIT) && from_act_d && krst_q);
    busy_d = (state_d == S_WAIT) || (state_d == S_GOFF) || (state_d == S_SWITCH);

    // Same-cycle set has priority over the clear pulse.
    ff_d = ff_set | (ff_q & ~fail_clr);
    fa_d = fa_set | (fa_q & ~fail_clr);
    te_d = te_set | (te_q & ~fail_clr);
  end

  assign clk_sel_o    = sel_q;
  assign clk_gate_en  = gate_q | testmode;
  assign ker_rst_n    = testmode ? ~rst : krst_q;
  assign busy         = busy_q;
  assign fail_flag    = ff_q;
  assign fallback_act = fa_q;
  assign timeout_err  = te_q;

endmodule

// File: tb/tb_rcc_ker_clk_sel_ctrl.sv
// Directed bench for rcc_ker_clk_sel_ctrl: a vector table for the basic switch/disable flow
// plus hand sequences for timeout, abort, fallback, async reset and testmode.
module tb_rcc_ker_clk_sel_ctrl;

  localparam int unsigned SRC_NUM = 4;
  localparam int unsigned SEL_W   = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             testmode = 1'b0;
  logic             sw_en = 1'b0;
  logic [SEL_W-1:0] sw_sel = '0;
  logic [3:0]       src_rdy = '0;
  logic [3:0]       src_fail = '0;
  logic             fail_clr = 1'b0;
  logic [SEL_W-1:0] clk_sel_o;
  logic             clk_gate_en, ker_rst_n, busy, fail_flag, fallback_act, timeout_err;

  int n_chk = 0;
  int n_fail = 0;

  rcc_ker_clk_sel_ctrl #(
    .SRC_NUM(SRC_NUM), .SEL_W(SEL_W), .FALLBACK_SRC(2), .CNT_W(8),
    .RDY_TIMEOUT(200), .GATE_CYC(4), .RST_HOLD(2)
  ) dut (
    .clk(clk), .rst(rst), .testmode(testmode), .sw_en(sw_en), .sw_sel(sw_sel),
    .src_rdy(src_rdy), .src_fail(src_fail), .fail_clr(fail_clr),
    .clk_sel_o(clk_sel_o), .clk_gate_en(clk_gate_en), .ker_rst_n(ker_rst_n),
    .busy(busy), .fail_flag(fail_flag), .fallback_act(fallback_act), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [2:0] sel;
    logic [3:0] rdy;
    logic [3:0] fail;
    int         ncyc;
    logic [2:0] e_sel;
    logic       e_gate;
    logic       e_krst;
    logic       e_busy;
    logic [2:0] e_flg;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] e_sel, input logic e_gate,
                         input logic e_krst, input logic e_busy, input logic [2:0] e_flg);
    chk({tag, ".sel"}, 32'(clk_sel_o), 32'(e_sel));
    chk({tag, ".gate"}, 32'(clk_gate_en), 32'(e_gate));
    chk({tag, ".krst_n"}, 32'(ker_rst_n), 32'(e_krst));
    chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
    chk({tag, ".flags"}, 32'({fail_flag, fallback_act, timeout_err}), 32'(e_flg));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic en, input logic [2:0] sel, input logic [3:0] rdy,
                       input logic [3:0] fail);
    sw_en    = en;
    sw_sel   = sel;
    src_rdy  = rdy;
    src_fail = fail;
  endtask

  initial begin
    // {en, sel, rdy, fail, ncyc, exp sel, gate, krst_n, busy, {ff,fa,te}}
    vecs[0]  = '{1'b1, 3'd3, 4'b0000, 4'b0000, 1, 3'd0, 1'b0, 1'b0, 1'b1, 3'b000};
    vecs[1]  = '{1'b1, 3'd3, 4'b0000, 4'b0000, 3, 3'd0, 1'b0, 1'b0, 1'b1, 3'b000};
    vecs[2]  = '{1'b1, 3'd3, 4'b1000, 4'b0000, 1, 3'd0, 1'b0, 1'b0, 1'b1, 3'b000};
    vecs[3]  = '{1'b1, 3'd3, 4'b1000, 4'b0000, 3, 3'd0, 1'b0, 1'b0, 1'b1, 3'b000};
    vecs[4]  = '{1'b1, 3'd3, 4'b1000, 4'b0000, 1, 3'd3, 1'b0, 1'b0, 1'b1, 3'b000};
    vecs[5]  = '{1'b1, 3'd3, 4'b1000, 4'b0000, 3, 3'd3, 1'b0, 1'b0, 1'b1, 3'b000};
    vecs[6]  = '{1'b1, 3'd3, 4'b1000, 4'b0000, 1, 3'd3, 1'b1, 1'b0, 1'b0, 3'b000};
    vecs[7]  = '{1'b1, 3'd3, 4'b1000, 4'b0000, 1, 3'd3, 1'b1, 1'b0, 1'b0, 3'b000};
    vecs[8]  = '{1'b1, 3'd3, 4'b1000, 4'b0000, 1, 3'd3, 1'b1, 1'b1, 1'b0, 3'b000};
    vecs[9]  = '{1'b1, 3'd3, 4'b1000, 4'b0000, 5, 3'd3, 1'b1, 1'b1, 1'b0, 3'b000};
    vecs[10] = '{1'b0, 3'd3, 4'b1000, 4'b0000, 1, 3'd3, 1'b0, 1'b0, 1'b1, 3'b000};
    vecs[11] = '{1'b0, 3'd3, 4'b1000, 4'b0000, 4, 3'd0, 1'b0, 1'b0, 1'b1, 3'b000};
    vecs[12] = '{1'b0, 3'd3, 4'b1000, 4'b0000, 4, 3'd0, 1'b0, 1'b0, 1'b0, 3'b000};
    vecs[13] = '{1'b1, 3'd4, 4'b1110, 4'b0000, 3, 3'd0, 1'b0, 1'b0, 1'b0, 3'b000};
    vecs[14] = '{1'b1, 3'd0, 4'b1110, 4'b0000, 3, 3'd0, 1'b0, 1'b0, 1'b0, 3'b000};
    vecs[15] = '{1'b0, 3'd3, 4'b1110, 4'b0000, 2, 3'd0, 1'b0, 1'b0, 1'b0, 3'b000};

    @(negedge clk);
    chk_all("reset", 3'd0, 1'b0, 1'b0, 1'b0, 3'b000);
    rst = 1'b0;
    step(1);
    chk_all("post_reset", 3'd0, 1'b0, 1'b0, 1'b0, 3'b000);

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].en, vecs[i].sel, vecs[i].rdy, vecs[i].fail);
      step(vecs[i].ncyc);
      chk_all($sformatf("vec%0d", i), vecs[i].e_sel, vecs[i].e_gate, vecs[i].e_krst,
              vecs[i].e_busy, vecs[i].e_flg);
    end

    // Ready timeout from IDLE, then clear
    drive(1'b1, 3'd1, 4'b0000, 4'b0000);
    step(200);
    chk_all("to_wait", 3'd0, 1'b0, 1'b0, 1'b1, 3'b000);
    step(1);
    chk_all("to_expired", 3'd0, 1'b0, 1'b0, 1'b0, 3'b001);
    sw_en = 1'b0;
    fail_clr = 1'b1;
    step(1);
    fail_clr = 1'b0;
    chk_all("to_clear", 3'd0, 1'b0, 1'b0, 1'b0, 3'b000);

    // Bring source 3 up, then request 1 which never becomes ready
    drive(1'b1, 3'd3, 4'b1110, 4'b0000);
    step(12);
    chk_all("act3", 3'd3, 1'b1, 1'b1, 1'b0, 3'b000);
    drive(1'b1, 3'd1, 4'b1100, 4'b0000);
    step(1);
    chk_all("abort_wait", 3'd3, 1'b1, 1'b1, 1'b1, 3'b000);
    step(200);
    chk_all("abort_back", 3'd3, 1'b1, 1'b1, 1'b0, 3'b001);
    drive(1'b1, 3'd3, 4'b1110, 4'b0000);
    fail_clr = 1'b1;
    step(1);
    fail_clr = 1'b0;
    chk_all("abort_clr", 3'd3, 1'b1, 1'b1, 1'b0, 3'b000);

    // Active source 3 fails, fallback to 2
    src_fail = 4'b1000;
    step(1);
    chk_all("fb_start", 3'd3, 1'b0, 1'b0, 1'b1, 3'b110);
    step(4);
    chk_all("fb_switch", 3'd2, 1'b0, 1'b0, 1'b1, 3'b110);
    step(4);
    chk_all("fb_active", 3'd2, 1'b1, 1'b0, 1'b0, 3'b110);
    sw_sel = 3'd1;
    step(5);
    chk_all("fb_ignore_sel", 3'd2, 1'b1, 1'b1, 1'b0, 3'b110);

    // Fallback source fails in the same cycle as a clear; new fail wins
    drive(1'b0, 3'd1, 4'b1110, 4'b0100);
    fail_clr = 1'b1;
    step(1);
    fail_clr = 1'b0;
    chk_all("fb2_fail", 3'd2, 1'b0, 1'b0, 1'b1, 3'b100);
    src_fail = 4'b0000;
    step(8);
    chk_all("fb2_idle", 3'd0, 1'b0, 1'b0, 1'b0, 3'b100);

    // Async reset in the middle of SWITCH
    drive(1'b1, 3'd3, 4'b1110, 4'b0000);
    step(7);
    chk_all("mid_switch", 3'd3, 1'b0, 1'b0, 1'b1, 3'b100);
    #1 rst = 1'b1;
    #1 chk_all("async_rst", 3'd0, 1'b0, 1'b0, 1'b0, 3'b000);
    sw_en = 1'b0;

    // testmode forces gate on, ker_rst_n follows reset
    testmode = 1'b1;
    #1;
    chk("tm_rst.gate", 32'(clk_gate_en), 32'd1);
    chk("tm_rst.krst_n", 32'(ker_rst_n), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("tm_run.krst_n", 32'(ker_rst_n), 32'd1);
    drive(1'b1, 3'd3, 4'b1110, 4'b0000);
    for (int c = 0; c < 14; c++) begin
      step(1);
      chk($sformatf("tm_gate%0d", c), 32'(clk_gate_en), 32'd1);
    end
    chk("tm_sel", 32'(clk_sel_o), 32'd3);
    testmode = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rcc_ker_clk_sel_ctrl.md
Name: rcc_ker_clk_sel_ctrl

Overview:
Parametrised kernel-clock source sequencer for RCC peripheral and RTC-style kernel clocks, running in the system clock domain. It sequences software source changes as request, ready-wait, gate-off, switch, settle and gate-on, and holds a kernel reset around each switch. Unlike the fixed 4-input selector, it supports N sources, ready timeout, and automatic fallback on a source failure with a sticky status. Its outputs drive a downstream glitch-free clock mux select, the clock-gate enable and the kernel reset.

Parameters:
SRC_NUM, 4, number of clock sources; index 0 is reserved as "no clock".
SEL_W, 2, select width; must satisfy 2**SEL_W >= SRC_NUM.
FALLBACK_SRC, 2, source used on failure of the active source; range 1..SRC_NUM-1.
CNT_W, 8, width of the shared cycle counter.
RDY_TIMEOUT, 200, WAIT_RDY cycles before timeout; must be < 2**CNT_W.
GATE_CYC, 4, cycles spent in each of GATE_OFF and SWITCH; minimum 1.
RST_HOLD, 2, ACTIVE cycles with ker_rst_n low after the gate opens; minimum 1.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
testmode  in  1  forces clk_gate_en=1 and ker_rst_n=~rst; FSM keeps running
sw_en  in  1  software kernel-clock enable
sw_sel  in  SEL_W  software source select
src_rdy  in  SRC_NUM  per-source ready, pre-synchronised to clk; bit 0 ignored
src_fail  in  SRC_NUM  per-source fail level, pre-synchronised; bit 0 ignored
fail_clr  in  1  one-cycle pulse; clears fail_flag, fallback_act and timeout_err
clk_sel_o  out  SEL_W  select to the clock mux
clk_gate_en  out  1  kernel clock gate enable
ker_rst_n  out  1  kernel reset, active low
busy  out  1  high in WAIT_RDY, GATE_OFF and SWITCH
fail_flag  out  1  sticky: the active source failed
fallback_act  out  1  sticky: the fallback source has been engaged
timeout_err  out  1  sticky: a ready-wait timed out

Behaviour:
- Reset state: state=IDLE, clk_sel_o=0, tgt=0, cnt=0, clk_gate_en=0, ker_rst_n=0, busy=0, all sticky flags=0.
- Effective request: req = (sw_en && sw_sel!=0 && sw_sel<SRC_NUM) ? sw_sel : 0.
- IDLE: gate off, ker_rst_n=0. If req!=0: tgt<=req, cnt<=0, go to WAIT_RDY.
- WAIT_RDY:
  - If src_rdy[tgt] && !src_fail[tgt]: cnt<=0, go to GATE_OFF.
  - Else if cnt==RDY_TIMEOUT-1: timeout_err<=1, go to IDLE; clk_sel_o unchanged.
  - Else cnt++.
  - If req changes while waiting: tgt<=req (or go to IDLE if req==0) and cnt restarts.
- GATE_OFF: clk_gate_en=0, ker_rst_n=0, for GATE_CYC cycles. On the last cycle: clk_sel_o<=tgt, cnt<=0, go to SWITCH.
- SWITCH: gate off for GATE_CYC cycles. Then go to ACTIVE if clk_sel_o!=0, else IDLE.
- ACTIVE: clk_gate_en=1 from the first ACTIVE cycle. ker_rst_n=0 for the first RST_HOLD cycles, then 1.
- ACTIVE events, in priority order:
  1. src_fail[clk_sel_o]: fail_flag<=1. If clk_sel_o!=FALLBACK_SRC and src_rdy[FALLBACK_SRC] and !src_fail[FALLBACK_SRC]: tgt<=FALLBACK_SRC, fallback_act<=1. Otherwise tgt<=0. Go to GATE_OFF; WAIT_RDY is skipped.
  2. fallback_act==0 and req!=clk_sel_o: if req==0, tgt<=0 and go to GATE_OFF. Otherwise tgt<=req and go to WAIT_RDY; the old clock stays gated on while waiting.
  3. fallback_act==1: software select changes are ignored. sw_en=0 still forces the switch to 0.
- Ready-wait abort from ACTIVE: if WAIT_RDY times out after being entered from ACTIVE, go back to ACTIVE with the gate kept on and set timeout_err.
- Sticky flags: fail_clr clears all three. A same-cycle set wins over clear.
- Mid-sequence failure: src_fail of the target during GATE_OFF or SWITCH does not abort; it is handled once ACTIVE is reached.
- rst at any time returns immediately to reset values, including mid-switch.

Test Plan:
- Basic switch: rst released, sw_en=1, sw_sel=3, src_rdy[3]=1 at cycle 5 -> busy rises 1 cycle after sw_en; clk_sel_o=3 after 4 gate-off cycles; gate on after 4 more; ker_rst_n=1 two cycles later.
- Timeout: sw_sel=1 with src_rdy[1]=0 held -> after 200 cycles timeout_err=1, state IDLE, clk_sel_o=0; fail_clr pulse -> timeout_err=0.
- Fallback: active source 3, src_fail[3]=1 with src 2 ready -> fail_flag=1, fallback_act=1, gate off for 8 cycles, clk_sel_o=2, gate re-enabled. A later sw_sel=1 is ignored until fail_clr.
- Fallback source itself fails: active source 2, src_fail[2]=1 -> clk_sel_o=0, IDLE, clk_gate_en=0, fail_flag=1, fallback_act=0.
- Disable and boundaries:
  - sw_en=0 while ACTIVE -> clk_sel_o=0 and ker_rst_n=0.
  - sw_sel=4 with SRC_NUM=4 -> treated as 0.
  - Simultaneous fail_clr and new fail -> fail_flag stays 1.
- Async reset mid-SWITCH and testmode:
  - rst mid-SWITCH -> all outputs take reset values within the same cycle.
  - testmode=1 -> clk_gate_en=1 throughout.
